// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port unified memory between instruction fetch (IF) and
// data load/store (D). Each access goes through three phases:
//   - arbitrate in IDLE
//   - drive the memory for one ACCESS cycle
//   - for reads, WAIT out the fixed read latency and return the data
//     to the requester that owns the access.
// Data wins ties. A starvation counter forces a fetch after STARVE_MAX
// consecutive data grants taken while a fetch was pending.
//
// Optional build macro: MEM_PORT_ARBITER_MISALIGN_EXC_EN
//   When defined, a misaligned data access is not issued to memory. The block
//   instead pulses d_misalign for one cycle and returns to IDLE.
module mem_port_arbiter #(
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4,
  parameter int AW         = 32
) (
  input  logic          clk,
  input  logic          Reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [31:0]   if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [31:0]   d_wdata,
  input  logic [1:0]    d_size,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [31:0]   d_rdata,
`ifdef MEM_PORT_ARBITER_MISALIGN_EXC_EN
  output logic          d_misalign,
`endif
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic [1:0]    mem_size,
  input  logic [31:0]   mem_rdata,
  output logic          busy,
  output logic          owner
);

  // Latency counter only has to hold MEM_LAT-1.
  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] LAT_LOAD   = CW'(MEM_LAT - 1);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_MISAL  = 2'd3
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [SW-1:0]   r_starve;
  logic            r_acc_we;
  logic            r_if_gnt;
  logic            r_d_gnt;
  logic            r_mem_en;
  logic            r_mem_we;
  logic [AW-1:0]   r_mem_addr;
  logic [31:0]     r_mem_wdata;
  logic [1:0]      r_mem_size;
  logic            r_owner;
  logic            r_if_rvalid;
  logic            r_d_rvalid;
  logic [31:0]     r_if_rdata;
  logic [31:0]     r_d_rdata;
`ifdef MEM_PORT_ARBITER_MISALIGN_EXC_EN
  logic            r_misal;
`endif

  logic            w_if_forced;
  logic            w_pick_d;
  logic            w_pick_if;
  logic            w_d_ok;
  logic [SW-1:0]   w_starve_d;

  // Saturating increment of the starvation count.
  function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] v);
    if (v >= STARVE_TOP) return STARVE_TOP;
    return v + SW'(1);
  endfunction

  // Arbitration decision for the current IDLE cycle.
  always_comb begin
    w_if_forced = if_req && (r_starve == STARVE_TOP);
    w_pick_d    = d_req && !w_if_forced;
    w_pick_if   = if_req && !w_pick_d;
    // A data grant only counts toward starvation while a fetch is waiting.
    w_starve_d  = if_req ? sat_inc(r_starve) : '0;
`ifdef MEM_PORT_ARBITER_MISALIGN_EXC_EN
    w_d_ok      = !(((d_size == 2'b00) && (d_addr[1:0] != 2'b00)) ||
                    ((d_size == 2'b01) && d_addr[0]));
`else
    w_d_ok      = 1'b1;
`endif
  end

  // Access sequencer: arbitrate, issue, wait for read data, respond.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_starve    <= '0;
      r_acc_we    <= 1'b0;
      r_if_gnt    <= 1'b0;
      r_d_gnt     <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_size  <= 2'b00;
      r_owner     <= 1'b0;
      r_if_rvalid <= 1'b0;
      r_d_rvalid  <= 1'b0;
      r_if_rdata  <= '0;
      r_d_rdata   <= '0;
`ifdef MEM_PORT_ARBITER_MISALIGN_EXC_EN
      r_misal     <= 1'b0;
`endif
    end else begin
      // Strobes are single-cycle pulses; only the states below raise them.
      r_if_gnt    <= 1'b0;
      r_d_gnt     <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_if_rvalid <= 1'b0;
      r_d_rvalid  <= 1'b0;
`ifdef MEM_PORT_ARBITER_MISALIGN_EXC_EN
      r_misal     <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (w_pick_d) begin
            r_starve <= w_starve_d;
            if (w_d_ok) begin
              r_d_gnt     <= 1'b1;
              r_mem_en    <= 1'b1;
              r_mem_we    <= d_we;
              r_acc_we    <= d_we;
              r_mem_addr  <= d_addr;
              r_mem_wdata <= d_wdata;
              r_mem_size  <= d_size;
              r_owner     <= 1'b1;
              r_state     <= S_ACCESS;
            end
`ifdef MEM_PORT_ARBITER_MISALIGN_EXC_EN
            else begin
              // Rejected access still consumes this arbitration slot.
              r_misal <= 1'b1;
              r_state <= S_MISAL;
            end
`endif
          end else if (w_pick_if) begin
            r_starve    <= '0;
            r_if_gnt    <= 1'b1;
            r_mem_en    <= 1'b1;
            r_mem_we    <= 1'b0;
            r_acc_we    <= 1'b0;
            r_mem_addr  <= if_addr;
            r_mem_wdata <= '0;
            r_mem_size  <= 2'b00;
            r_owner     <= 1'b0;
            r_state     <= S_ACCESS;
          end else begin
            // No request at all implies no fetch is pending.
            r_starve <= '0;
          end
        end
        S_ACCESS: begin
          if (r_acc_we) begin
            r_state <= S_IDLE;
          end else begin
            r_cnt   <= LAT_LOAD;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
          end else begin
            // Only the owner's data register moves; the other side holds.
            if (r_owner) begin
              r_d_rdata  <= mem_rdata;
              r_d_rvalid <= 1'b1;
            end else begin
              r_if_rdata  <= mem_rdata;
              r_if_rvalid <= 1'b1;
            end
            r_state <= S_IDLE;
          end
        end
        // Misalign bounce and any unexpected encoding both go back to IDLE.
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign if_gnt     = r_if_gnt;
  assign if_rvalid  = r_if_rvalid;
  assign if_rdata   = r_if_rdata;
  assign d_gnt      = r_d_gnt;
  assign d_rvalid   = r_d_rvalid;
  assign d_rdata    = r_d_rdata;
`ifdef MEM_PORT_ARBITER_MISALIGN_EXC_EN
  assign d_misalign = r_misal;
`endif
  assign mem_en     = r_mem_en;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign mem_size   = r_mem_size;
  assign busy       = (r_state != S_IDLE);
  assign owner      = r_owner;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Two arbiters share one stimulus stream:
//   - instance 0: MEM_LAT=2, STARVE_MAX=2
//   - instance 1: MEM_LAT=1, STARVE_MAX=4
// A transaction-level model schedules the expected grant, strobe and response
// cycles from the latency equations. Every negedge it compares all outputs of
// both instances against that model. Directed sections add literal checks.
module tb_mem_port_arbiter;

  logic        clk;
  logic        Reset;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic [1:0]  d_size;
  logic        rd_hold;

  logic        if_gnt [2];
  logic        if_rvalid [2];
  logic        d_gnt [2];
  logic        d_rvalid [2];
  logic        mem_en [2];
  logic        mem_we [2];
  logic        busy [2];
  logic        owner [2];
  logic [31:0] if_rdata [2];
  logic [31:0] d_rdata [2];
  logic [31:0] mem_addr [2];
  logic [31:0] mem_wdata [2];
  logic [1:0]  mem_size [2];
`ifdef MEM_PORT_ARBITER_MISALIGN_EXC_EN
  logic        d_misal [2];
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  mem_port_arbiter #(.MEM_LAT(2), .STARVE_MAX(2), .AW(32)) u_a (
    .clk(clk), .Reset(Reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt[0]),
    .if_rvalid(if_rvalid[0]), .if_rdata(if_rdata[0]),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_size(d_size), .d_gnt(d_gnt[0]), .d_rvalid(d_rvalid[0]),
    .d_rdata(d_rdata[0]),
`ifdef MEM_PORT_ARBITER_MISALIGN_EXC_EN
    .d_misalign(d_misal[0]),
`endif
    .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .mem_size(mem_size[0]), .mem_rdata(mem_rdata),
    .busy(busy[0]), .owner(owner[0])
  );

  mem_port_arbiter #(.MEM_LAT(1), .STARVE_MAX(4), .AW(32)) u_b (
    .clk(clk), .Reset(Reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt[1]),
    .if_rvalid(if_rvalid[1]), .if_rdata(if_rdata[1]),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_size(d_size), .d_gnt(d_gnt[1]), .d_rvalid(d_rvalid[1]),
    .d_rdata(d_rdata[1]),
`ifdef MEM_PORT_ARBITER_MISALIGN_EXC_EN
    .d_misalign(d_misal[1]),
`endif
    .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .mem_size(mem_size[1]), .mem_rdata(mem_rdata),
    .busy(busy[1]), .owner(owner[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : 1;
  endfunction

  function automatic int sm_of(input int k);
    return (k == 0) ? 2 : 4;
  endfunction

  task automatic chk(input string name, input int k,
                     input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d cyc %0d: got %h expected %h", name, k, cyc, act, exp);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // Per-cycle pulse expectations live in 16-slot rings indexed by cycle.
  logic [15:0] s_ifg [2];
  logic [15:0] s_dg [2];
  logic [15:0] s_en [2];
  logic [15:0] s_we [2];
  logic [15:0] s_ifv [2];
  logic [15:0] s_dv [2];
  logic [15:0] s_mis [2];
  logic [31:0] e_addr [2];
  logic [31:0] e_wdata [2];
  logic [31:0] e_ifr [2];
  logic [31:0] e_dr [2];
  logic [1:0]  e_size [2];
  logic        e_own [2];
  logic        cap_own [2];
  int          next_arb [2];
  int          cap [2];
  int          sc [2];

  task automatic issue(input int k, input logic who, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic we, input logic [1:0] size);
    int ns;
    ns = (cyc + 1) % 16;
    if (who) s_dg[k][ns] = 1'b1;
    else     s_ifg[k][ns] = 1'b1;
    s_en[k][ns] = 1'b1;
    s_we[k][ns] = we;
    e_addr[k]   = addr;
    e_wdata[k]  = wdata;
    e_size[k]   = size;
    e_own[k]    = who;
    if (we) begin
      next_arb[k] = cyc + 2;
    end else begin
      cap[k]      = cyc + 1 + lat_of(k);
      cap_own[k]  = who;
      next_arb[k] = cyc + 2 + lat_of(k);
    end
  endtask

  task automatic model_step(input int k);
    int   sl;
    logic wd, wi, mis;
    sl = cyc % 16;
    if (Reset) begin
      s_ifg[k] = '0; s_dg[k] = '0; s_en[k] = '0; s_we[k] = '0;
      s_ifv[k] = '0; s_dv[k] = '0; s_mis[k] = '0;
      e_addr[k] = '0; e_wdata[k] = '0; e_ifr[k] = '0; e_dr[k] = '0;
      e_size[k] = '0; e_own[k] = 1'b0; cap_own[k] = 1'b0;
      sc[k] = 0; cap[k] = -1; next_arb[k] = cyc;
    end
    chk("if_gnt",    k, if_gnt[k],    s_ifg[k][sl]);
    chk("d_gnt",     k, d_gnt[k],     s_dg[k][sl]);
    chk("mem_en",    k, mem_en[k],    s_en[k][sl]);
    chk("mem_we",    k, mem_we[k],    s_we[k][sl]);
    chk("if_rvalid", k, if_rvalid[k], s_ifv[k][sl]);
    chk("d_rvalid",  k, d_rvalid[k],  s_dv[k][sl]);
    chk("mem_addr",  k, mem_addr[k],  e_addr[k]);
    chk("mem_wdata", k, mem_wdata[k], e_wdata[k]);
    chk("mem_size",  k, mem_size[k],  e_size[k]);
    chk("if_rdata",  k, if_rdata[k],  e_ifr[k]);
    chk("d_rdata",   k, d_rdata[k],   e_dr[k]);
    chk("owner",     k, owner[k],     e_own[k]);
    chk("busy",      k, busy[k],      (!Reset && cyc < next_arb[k]) ? 1'b1 : 1'b0);
`ifdef MEM_PORT_ARBITER_MISALIGN_EXC_EN
    chk("d_misalign", k, d_misal[k],  s_mis[k][sl]);
`endif
    s_ifg[k][sl] = 1'b0; s_dg[k][sl] = 1'b0; s_en[k][sl] = 1'b0;
    s_we[k][sl] = 1'b0; s_ifv[k][sl] = 1'b0; s_dv[k][sl] = 1'b0;
    s_mis[k][sl] = 1'b0;
    if (!Reset) begin
      if (cap[k] == cyc) begin
        if (cap_own[k]) begin
          e_dr[k] = mem_rdata;
          s_dv[k][(cyc + 1) % 16] = 1'b1;
        end else begin
          e_ifr[k] = mem_rdata;
          s_ifv[k][(cyc + 1) % 16] = 1'b1;
        end
        cap[k] = -1;
      end
      if (cyc >= next_arb[k]) begin
        wd = d_req && !(if_req && sc[k] == sm_of(k));
        wi = if_req && !wd;
        mis = 1'b0;
`ifdef MEM_PORT_ARBITER_MISALIGN_EXC_EN
        mis = ((d_size == 2'b00) && (d_addr[1:0] != 2'b00)) ||
              ((d_size == 2'b01) && d_addr[0]);
`endif
        if (wd) begin
          sc[k] = if_req ? ((sc[k] < sm_of(k)) ? sc[k] + 1 : sm_of(k)) : 0;
          if (mis) begin
            s_mis[k][(cyc + 1) % 16] = 1'b1;
            next_arb[k] = cyc + 2;
          end else begin
            issue(k, 1'b1, d_addr, d_wdata, d_we, d_size);
          end
        end else if (wi) begin
          sc[k] = 0;
          issue(k, 1'b0, if_addr, 32'h0, 1'b0, 2'b00);
        end else begin
          sc[k] = 0;
        end
      end
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) model_step(k);
    cyc++;
  end

  // ---------------- directed stimulus ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (!rd_hold) mem_rdata = 32'hC0DE_0000 + 32'(cyc);
    end
  endtask

  int q[$];
  int exp_ord [6] = '{1, 1, 0, 1, 1, 0};

  initial begin
    Reset = 1'b1; rd_hold = 1'b0;
    if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; d_size = 2'b00; mem_rdata = '0;

    step(2);
    @(negedge clk);
    chk("rst_busy", 0, busy[0], 1'b0);
    chk("rst_addr", 0, mem_addr[0], 32'h0);
    chk("rst_en",   1, mem_en[1], 1'b0);
    step(1);
    Reset = 1'b0;
    step(1);

    // Fetch read, MEM_LAT=2 on instance 0.
    if_req = 1'b1; if_addr = 32'h10; rd_hold = 1'b1; mem_rdata = 32'hDEADBEEF;
    step(1);
    @(negedge clk);
    chk("t1_gnt",  0, if_gnt[0], 1'b1);
    chk("t1_en",   0, mem_en[0], 1'b1);
    chk("t1_addr", 0, mem_addr[0], 32'h10);
    chk("t1_busy1", 0, busy[0], 1'b1);
    step(1);
    if_req = 1'b0;
    @(negedge clk);
    chk("t1_busy2", 0, busy[0], 1'b1);
    step(1);
    @(negedge clk);
    chk("t1_busy3", 0, busy[0], 1'b1);
    chk("t1_b_rv", 1, if_rvalid[1], 1'b1);
    chk("t1_b_rd", 1, if_rdata[1], 32'hDEADBEEF);
    step(1);

    // Load with MEM_LAT=1 on instance 1, issued in the rvalid cycle of instance 0.
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20; d_size = 2'b00;
    mem_rdata = 32'hA5A5A5A5;
    @(negedge clk);
    chk("t1_rv", 0, if_rvalid[0], 1'b1);
    chk("t1_rd", 0, if_rdata[0], 32'hDEADBEEF);
    chk("t1_idle", 0, busy[0], 1'b0);
    step(1);
    d_req = 1'b0;
    @(negedge clk);
    chk("t4_gnt",  1, d_gnt[1], 1'b1);
    chk("t4_addr", 1, mem_addr[1], 32'h20);
    step(1);
    @(negedge clk);
    chk("t4_norv", 1, d_rvalid[1], 1'b0);
    step(1);
    @(negedge clk);
    chk("t4_rv",   1, d_rvalid[1], 1'b1);
    chk("t4_rd",   1, d_rdata[1], 32'hA5A5A5A5);
    chk("t4_ifrd", 1, if_rdata[1], 32'hDEADBEEF);
    step(1);
    rd_hold = 1'b0;

    // Store to 0x100.
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'h12345678; d_size = 2'b00;
    @(negedge clk);
    chk("t4a_rv", 0, d_rvalid[0], 1'b1);
    chk("t4a_rd", 0, d_rdata[0], 32'hA5A5A5A5);
    step(1);
    d_req = 1'b0; d_we = 1'b0;
    @(negedge clk);
    chk("t2_en",    0, mem_en[0], 1'b1);
    chk("t2_we",    0, mem_we[0], 1'b1);
    chk("t2_addr",  0, mem_addr[0], 32'h100);
    chk("t2_wdata", 0, mem_wdata[0], 32'h12345678);
    chk("t2_size",  0, mem_size[0], 2'b00);
    chk("t2_gnt",   0, d_gnt[0], 1'b1);
    step(1);
    @(negedge clk);
    chk("t2_idle", 0, busy[0], 1'b0);
    chk("t2_norv", 0, d_rvalid[0], 1'b0);
    chk("t2_hold", 0, mem_addr[0], 32'h100);
    chk("t2_weoff", 0, mem_we[0], 1'b0);
    step(1);

    // Both requesters held: instance 0 (STARVE_MAX=2) must grant D,D,IF,D,D,IF.
    if_req = 1'b1; if_addr = 32'h300; d_req = 1'b1; d_we = 1'b0;
    d_addr = 32'h200; d_size = 2'b00;
    q.delete();
    for (int i = 0; i < 80 && q.size() < 6; i++) begin
      @(negedge clk);
      if (if_gnt[0]) q.push_back(0);
      if (d_gnt[0]) q.push_back(1);
      step(1);
    end
    chk("t3_count", 0, q.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < q.size()) chk("t3_order", 0, q[i], exp_ord[i]);
    end
    if_req = 1'b0; d_req = 1'b0;
    step(10);

    // Reset during the WAIT of a fetch on instance 0.
    if_req = 1'b1; if_addr = 32'h40;
    step(1);
    if_req = 1'b0;
    step(1);
    Reset = 1'b1;
    #1;
    chk("t5_busy",  0, busy[0], 1'b0);
    chk("t5_addr",  0, mem_addr[0], 32'h0);
    chk("t5_ifrd",  0, if_rdata[0], 32'h0);
    chk("t5_own",   0, owner[0], 1'b0);
    chk("t5_b_addr", 1, mem_addr[1], 32'h0);
    step(1);
    Reset = 1'b0;
    @(negedge clk);
    chk("t5_norv0", 0, if_rvalid[0], 1'b0);
    step(1);
    @(negedge clk);
    chk("t5_norv1", 0, if_rvalid[0], 1'b0);
    step(1);
    if_req = 1'b1; if_addr = 32'h44;
    step(1);
    if_req = 1'b0;
    @(negedge clk);
    chk("t5_gnt",  0, if_gnt[0], 1'b1);
    chk("t5_addr2", 0, mem_addr[0], 32'h44);
    step(6);

`ifdef MEM_PORT_ARBITER_MISALIGN_EXC_EN
    // Misaligned word load is rejected with a one-cycle d_misalign pulse.
    d_req = 1'b1; d_we = 1'b0; d_size = 2'b00; d_addr = 32'h102;
    step(1);
    d_req = 1'b0;
    @(negedge clk);
    chk("t6_mis", 0, d_misal[0], 1'b1);
    chk("t6_en",  0, mem_en[0], 1'b0);
    chk("t6_gnt", 0, d_gnt[0], 1'b0);
    step(1);
    @(negedge clk);
    chk("t6_mis_off", 0, d_misal[0], 1'b0);
    chk("t6_idle",    0, busy[0], 1'b0);
    step(4);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences and shares one single-port unified memory between two requesters: instruction fetch (IF) and data load/store (D), both driven by the multicycle control unit's fetch and load/store states.
- Arbitrates, registers the access, drives the memory for one cycle, waits a fixed read latency, then returns read data to the owning requester.
- Data has priority. A starvation counter guarantees fetch progress.

Parameters:
- MEM_LAT, 2, memory read latency in cycles (≥1); mem_rdata is valid MEM_LAT cycles after the mem_en cycle.
- STARVE_MAX, 4, consecutive data grants allowed while if_req is pending before fetch is forced (≥1).
- AW, 32, address width.

Ports:
- clk  in  1  clock
- Reset  in  1  reset, asynchronous, active-high
- if_req  in  1  fetch request; held until if_gnt
- if_addr  in  AW  fetch address
- if_gnt  out  1  one-cycle grant pulse; high in the ACCESS cycle
- if_rvalid  out  1  one-cycle read-data-valid pulse
- if_rdata  out  32  fetch read data; held until next fetch response
- d_req  in  1  data request; held until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  AW  data address
- d_wdata  in  32  store data
- d_size  in  2  00 word, 01 half, 10 byte
- d_gnt  out  1  one-cycle grant pulse
- d_rvalid  out  1  one-cycle load-data-valid pulse
- d_rdata  out  32  load data; held until next data response
- mem_en  out  1  memory access strobe, one cycle
- mem_we  out  1  write enable, valid with mem_en
- mem_addr  out  AW  registered access address
- mem_wdata  out  32  registered store data
- mem_size  out  2  registered size; 00 for fetch
- mem_rdata  in  32  memory read data
- busy  out  1  high whenever state ≠ IDLE
- owner  out  1  0 = IF, 1 = D; owner of current or last access

Behaviour:
- Reset (asynchronous, any state): state = IDLE.
  - All outputs are 0, and starve_cnt = 0.
  - An in-flight read is discarded; no rvalid is produced after reset.
- States:
  - IDLE: arbitration occurs only here. Requests seen in ACCESS or WAIT are ignored until the next IDLE.
    - No request: stay in IDLE.
    - Winner = D if d_req and not (if_req and starve_cnt == STARVE_MAX); otherwise IF if if_req.
    - On the edge leaving IDLE, the winner's addr, wdata, we and size are registered into mem_*. owner is set, and state goes to ACCESS.
  - ACCESS (1 cycle): mem_en = 1 and the winner's gnt = 1.
    - Store: go to IDLE. There is no rvalid for stores.
    - Read: go to WAIT with cnt = MEM_LAT-1.
  - WAIT: if cnt ≠ 0, decrement.
    - If cnt == 0, capture mem_rdata into the owner's rdata and go to IDLE.
    - The owner's rvalid = 1 during that next IDLE cycle.
- Latency (read): request sampled in IDLE at cycle t gives gnt/mem_en at t+1 and rvalid at t+2+MEM_LAT.
- Latency (store): gnt/mem_en at t+1, and a new arbitration at t+2.
- Arbitration may occur in the same IDLE cycle in which rvalid is high, giving back-to-back service.
- Requester rule: drop req in the cycle after gnt unless another access is wanted. A req still high in the next IDLE counts as a new request.
- starve_cnt:
  - Increments (saturating at STARVE_MAX) on each D grant while if_req = 1.
  - Clears on an IF grant, or whenever if_req = 0 in IDLE.
- Simultaneous if_req and d_req with starve_cnt < STARVE_MAX: D wins.
- mem_* outputs hold their last value outside ACCESS; only mem_en and mem_we return to 0.
- The other requester's rdata is never modified by a response.

Optional Feature:
- Macro: MEM_PORT_ARBITER_MISALIGN_EXC_EN.
- With the macro defined:
  - A D grant candidate is misaligned if d_size = 00 with d_addr[1:0] ≠ 0, or d_size = 01 with d_addr[0] ≠ 0.
  - A misaligned candidate is not issued: no mem_en, no gnt.
  - Instead, output d_misalign (1 bit) pulses for one cycle, and the arbiter returns to IDLE the next cycle. starve_cnt is treated as a D grant.
- Without the macro: the address is passed unchanged, and the d_misalign port is absent.

Test Plan:
- MEM_LAT=2, if_req=1 with if_addr=0x10 at cycle 0, mem_rdata=0xDEADBEEF at cycle 3 → if_gnt=1, mem_en=1, mem_addr=0x10 at cycle 1; if_rvalid=1, if_rdata=0xDEADBEEF at cycle 4; busy high in cycles 1–3.
- Store with d_we=1, d_addr=0x100, d_wdata=0x12345678, d_size=00 → mem_en=1, mem_we=1 with those values one cycle after the request; d_rvalid never asserts; back in IDLE the following cycle.
- if_req and d_req (loads) both held continuously, STARVE_MAX=2 → grant order D, D, IF, D, D, IF.
- MEM_LAT=1, load to 0x20 returning 0xA5A5A5A5 → d_rvalid two cycles after d_gnt; if_rdata unchanged.
- Reset asserted in the WAIT state of a fetch read → all outputs 0 immediately; no if_rvalid afterwards; next request is granted normally.
- With MEM_PORT_ARBITER_MISALIGN_EXC_EN, load with d_size=00 and d_addr=0x102 → d_misalign pulse, no mem_en, no d_gnt.
